// File: rtl/clock_counter.sv
// clock_counter: timekeeping core of the digital clock.
// Holds seconds, minutes and hours as binary counts. Advances on the 1 Hz
// strobe while enabled, and supports button-driven setting on the set strobe.
//
// Optional feature: define CLOCK_12HR_EN for 12-hour mode (hours 1-12 with
// an active o_pm flag). Without it the clock runs 0-23 and o_pm stays 0.
//
// Ports:
//   i_clk          system clock
//   i_reset_n      asynchronous, active-low reset
//   i_en           run enable (gates 1 Hz counting only)
//   i_1hz_stb      single-cycle strobe, once per second
//   i_set_stb      single-cycle strobe at the set rate
//   i_set_hours    level, debounced "set hours" button
//   i_set_minutes  level, debounced "set minutes" button
//   o_seconds      seconds 0-59
//   o_minutes      minutes 0-59
//   o_hours        hours 0-23 (1-12 in 12-hour mode)
//   o_pm           PM flag (12-hour mode only)
//   o_rollover     one-cycle pulse on day wrap
module clock_counter #(
   parameter int unsigned RESET_HOURS   = 0,
   parameter int unsigned RESET_MINUTES = 0,
   parameter int unsigned RESET_SECONDS = 0
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic         i_en,
   input  logic         i_1hz_stb,
   input  logic         i_set_stb,
   input  logic         i_set_hours,
   input  logic         i_set_minutes,
   output logic [5:0]   o_seconds,
   output logic [5:0]   o_minutes,
   output logic [5:0]   o_hours,
   output logic         o_pm,
   output logic         o_rollover
);

   localparam int unsigned W = 6;

`ifdef CLOCK_12HR_EN
   localparam logic [W-1:0] HOURS_INIT = W'(12);
`else
   localparam logic [W-1:0] HOURS_INIT = W'(RESET_HOURS);
`endif
   localparam logic [W-1:0] MINUTES_INIT = W'(RESET_MINUTES);
   localparam logic [W-1:0] SECONDS_INIT = W'(RESET_SECONDS);

   typedef enum logic {
      RUN = 1'b0,
      SET = 1'b1
   } state_t;

   state_t         state, next_state;
   logic [W-1:0]   sec_q, min_q, hr_q;
   logic [W-1:0]   sec_n, min_n, hr_n;
   logic           pm_q, pm_n;
   logic           roll_q, roll_n;
   logic           set_active;
   logic [W-1:0]   hr_inc;
   logic           pm_inc;
   logic           day_wrap;

   assign set_active = i_set_hours | i_set_minutes;

   // State and time registers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state  <= RUN;
         sec_q  <= SECONDS_INIT;
         min_q  <= MINUTES_INIT;
         hr_q   <= HOURS_INIT;
         pm_q   <= 1'b0;
         roll_q <= 1'b0;
      end else begin
         state  <= next_state;
         sec_q  <= sec_n;
         min_q  <= min_n;
         hr_q   <= hr_n;
         pm_q   <= pm_n;
         roll_q <= roll_n;
      end
   end

   // Next state and next time values.
   always_comb begin
      next_state = state;
      sec_n      = sec_q;
      min_n      = min_q;
      hr_n       = hr_q;
      pm_n       = pm_q;
      roll_n     = 1'b0;

      // One-hour advance, shared by counting and setting.
`ifdef CLOCK_12HR_EN
      hr_inc   = (hr_q == W'(12)) ? W'(1) : hr_q + W'(1);
      pm_inc   = (hr_q == W'(11)) ? ~pm_q : pm_q;
      day_wrap = (hr_q == W'(11)) && pm_q;
`else
      hr_inc   = (hr_q == W'(23)) ? W'(0) : hr_q + W'(1);
      pm_inc   = 1'b0;
      day_wrap = (hr_q == W'(23));
`endif

      case (state)
         RUN:     if (set_active)  next_state = SET;
         SET:     if (!set_active) next_state = RUN;
         default: next_state = RUN;
      endcase

      // Behaviour follows the state being entered, so set levels win
      // over a coincident 1 Hz strobe on the very first edge.
      if (next_state == SET) begin
         sec_n = W'(0);
         if (i_set_stb) begin
            if (i_set_minutes)
               min_n = (min_q == W'(59)) ? W'(0) : min_q + W'(1);
            if (i_set_hours) begin
               hr_n = hr_inc;
               pm_n = pm_inc;
            end
         end
      end else if (i_en && i_1hz_stb) begin
         if (sec_q == W'(59)) begin
            sec_n = W'(0);
            if (min_q == W'(59)) begin
               min_n  = W'(0);
               hr_n   = hr_inc;
               pm_n   = pm_inc;
               roll_n = day_wrap;
            end else begin
               min_n = min_q + W'(1);
            end
         end else begin
            sec_n = sec_q + W'(1);
         end
      end
   end

   assign o_seconds  = sec_q;
   assign o_minutes  = min_q;
   assign o_hours    = hr_q;
   assign o_pm       = pm_q;
   assign o_rollover = roll_q;

endmodule

// File: tb/tb_clock_counter.sv
// Bench for clock_counter: vector table, directed corner sequences and
// randomized stimulus against a time-of-day reference model.
module tb_clock_counter;

   localparam int unsigned RH = 0;
   localparam int unsigned RM = 0;
   localparam int unsigned RS = 0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0, hz = 1'b0, sstb = 1'b0, sh = 1'b0, sm = 1'b0;
   logic [5:0] seconds, minutes, hours;
   logic       pm, rollover;

   int compared = 0;
   int mismatched = 0;

   // Reference state: 24-hour time of day plus last-cycle rollover.
   int  m_h, m_m, m_s;
   bit  m_roll;

   clock_counter #(.RESET_HOURS(RH), .RESET_MINUTES(RM), .RESET_SECONDS(RS)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_en(en), .i_1hz_stb(hz),
      .i_set_stb(sstb), .i_set_hours(sh), .i_set_minutes(sm),
      .o_seconds(seconds), .o_minutes(minutes), .o_hours(hours),
      .o_pm(pm), .o_rollover(rollover)
   );

   always #5 clk = ~clk;

   // Displayed hour and PM flag derived from a 24-hour value.
   function automatic int disp_h(input int h24);
`ifdef CLOCK_12HR_EN
      return (h24 % 12 == 0) ? 12 : h24 % 12;
`else
      return h24;
`endif
   endfunction

   function automatic bit disp_pm(input int h24);
`ifdef CLOCK_12HR_EN
      return h24 >= 12;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [19:0] pack(input int h24, input int mi, input int s, input bit r);
      return {6'(disp_h(h24)), 6'(mi), 6'(s), disp_pm(h24), r};
   endfunction

   task automatic model_reset();
`ifdef CLOCK_12HR_EN
      m_h = 0;
`else
      m_h = RH;
`endif
      m_m = RM; m_s = RS; m_roll = 1'b0;
   endtask

   // Time of day as a single count of seconds; fields derived arithmetically.
   task automatic model_step(input bit e, input bit h1, input bit ss, input bit bh, input bit bm);
      int t;
      m_roll = 1'b0;
      if (bh || bm) begin
         m_s = 0;
         if (ss) begin
            if (bm) m_m = (m_m + 1) % 60;
            if (bh) m_h = (m_h + 1) % 24;
         end
      end else if (e && h1) begin
         t = m_h * 3600 + m_m * 60 + m_s + 1;
         if (t == 86400) begin
            t = 0;
            m_roll = 1'b1;
         end
         m_h = t / 3600; m_m = (t / 60) % 60; m_s = t % 60;
      end
   endtask

   task automatic check(input string name, input logic [19:0] exp);
      logic [19:0] act;
      act = {hours, minutes, seconds, pm, rollover};
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d:%0d:%0d pm=%0b roll=%0b, expected %0d:%0d:%0d pm=%0b roll=%0b",
                  name, act[19:14], act[13:8], act[7:2], act[1], act[0],
                  exp[19:14], exp[13:8], exp[7:2], exp[1], exp[0]);
      end
   endtask

   task automatic tick(input bit e, input bit h1, input bit ss, input bit bh, input bit bm);
      en = e; hz = h1; sstb = ss; sh = bh; sm = bm;
      @(posedge clk);
      model_step(e, h1, ss, bh, bm);
      #1;
      check("model", pack(m_h, m_m, m_s, m_roll));
   endtask

   task automatic strobes(input int n, input bit e, input bit h1, input bit ss, input bit bh, input bit bm);
      for (int i = 0; i < n; i++) tick(e, h1, ss, bh, bm);
   endtask

   typedef struct {
      bit e, h1, ss, bh, bm;
      int h, mi, s;
   } vec_t;

   vec_t vecs[10];

   initial begin
      vecs[0] = '{1, 1, 0, 0, 0, 0, 0, 1};   // count
      vecs[1] = '{0, 1, 0, 0, 0, 0, 0, 1};   // disabled: strobe ignored
      vecs[2] = '{1, 0, 0, 0, 0, 0, 0, 1};   // no strobe
      vecs[3] = '{1, 1, 0, 0, 1, 0, 0, 0};   // enter set: seconds forced 0, 1 Hz ignored
      vecs[4] = '{1, 0, 1, 0, 1, 0, 1, 0};   // set minutes
      vecs[5] = '{1, 1, 1, 1, 1, 1, 2, 0};   // set both on one strobe
      vecs[6] = '{0, 0, 1, 1, 0, 2, 2, 0};   // set works with i_en=0
      vecs[7] = '{1, 1, 0, 0, 0, 2, 2, 1};   // release, first count -> 1
      vecs[8] = '{1, 0, 1, 0, 0, 2, 2, 1};   // set strobe in RUN ignored
      vecs[9] = '{1, 1, 1, 0, 0, 2, 2, 2};   // set strobe in RUN with count

      // Reset state
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      check("reset_state", pack(RH, RM, RS, 0));
      rst_n = 1'b1;

      // Vector table from reset
      foreach (vecs[i]) begin
         tick(vecs[i].e, vecs[i].h1, vecs[i].ss, vecs[i].bh, vecs[i].bm);
         check($sformatf("vec%0d", i), pack(vecs[i].h, vecs[i].mi, vecs[i].s, 0));
      end

      // Test 1: 61 counts from reset
      rst_n = 1'b0; #1; model_reset(); rst_n = 1'b1;
      strobes(61, 1, 1, 0, 0, 0);
      check("t1_00_01_01", pack(0, 1, 1, 0));

      // Test 2: preload 23:59 via set, count to midnight
      strobes(23, 1, 0, 1, 1, 0);
      strobes(58, 1, 0, 1, 0, 1);
      check("t2_preload", pack(23, 59, 0, 0));
      strobes(59, 1, 1, 0, 0, 0);
      check("t2_23_59_59", pack(23, 59, 59, 0));
      tick(1, 1, 0, 0, 0);
      check("t2_midnight", pack(0, 0, 0, 1));
      tick(1, 0, 0, 0, 0);
      check("t2_roll_cleared", pack(0, 0, 0, 0));

      // Test 3: from 00:58:37 hold set minutes
      strobes(58, 1, 0, 1, 0, 1);
      strobes(37, 1, 1, 0, 0, 0);
      check("t3_start", pack(0, 58, 37, 0));
      tick(1, 1, 0, 0, 1);
      check("t3_sec_forced", pack(0, 58, 0, 0));
      tick(1, 1, 1, 0, 1);
      tick(1, 1, 1, 0, 1);
      check("t3_min_wrap", pack(0, 0, 0, 0));

      // Test 4: both buttons, 25 strobes, then enable gating
      strobes(25, 1, 0, 1, 1, 1);
      check("t4_set_both", pack(1, 25, 0, 0));
      strobes(10, 0, 1, 0, 0, 0);
      check("t4_disabled", pack(1, 25, 0, 0));
      tick(1, 1, 0, 0, 0);
      check("t4_first_count", pack(1, 25, 1, 0));

      // Test 5: async reset mid-set at 13:42
      strobes(12, 1, 0, 1, 1, 0);
      strobes(17, 1, 0, 1, 0, 1);
      tick(1, 0, 0, 1, 0);
      check("t5_13_42", pack(13, 42, 0, 0));
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("t5_async_reset", pack(RH, RM, RS, 0));
      sh = 1'b0; hz = 1'b1; en = 1'b1;
      @(posedge clk); #1;
      check("t5_held_in_reset", pack(RH, RM, RS, 0));
      rst_n = 1'b1;
      tick(1, 1, 0, 0, 0);
      check("t5_run_after", pack(RH, RM, RS + 1, 0));

`ifdef CLOCK_12HR_EN
      // Test 6: 12-hour mode through noon and 12:59:59 -> 01:00:00
      rst_n = 1'b0; #1; model_reset(); rst_n = 1'b1;
      check("t6_reset_12am", {6'd12, 6'd0, 6'd0, 1'b0, 1'b0});
      strobes(11, 1, 0, 1, 1, 0);
      strobes(59, 1, 0, 1, 0, 1);
      strobes(59, 1, 1, 0, 0, 0);
      check("t6_11_59_59", {6'd11, 6'd59, 6'd59, 1'b0, 1'b0});
      tick(1, 1, 0, 0, 0);
      check("t6_noon", {6'd12, 6'd0, 6'd0, 1'b1, 1'b0});
      strobes(3599, 1, 1, 0, 0, 0);
      check("t6_12_59_59", {6'd12, 6'd59, 6'd59, 1'b1, 1'b0});
      tick(1, 1, 0, 0, 0);
      check("t6_1pm", {6'd1, 6'd0, 6'd0, 1'b1, 1'b0});
`endif

      // Randomized stimulus against the model
      for (int i = 0; i < 3000; i++) begin
         tick($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 7) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/clock_counter.md
Name: clock_counter

Overview:
- Timekeeping core of the digital clock; holds seconds, minutes and hours as binary counts.
- Advances once per 1 Hz strobe.
- Supports button-driven time setting at a strobed set rate.
- Sits directly upstream of the binary-to-BCD converters. Each 6-bit output feeds one converter, whose digit pair drives the display.

Parameters:
- RESET_HOURS, 0, hours value loaded on reset; legal range 0-23.
- RESET_MINUTES, 0, minutes value loaded on reset; legal range 0-59.
- RESET_SECONDS, 0, seconds value loaded on reset; legal range 0-59.

Ports:
- i_clk  input  1  system clock
- i_reset_n  input  1  asynchronous, active-low reset
- i_en  input  1  run enable; gates normal 1 Hz counting only
- i_1hz_stb  input  1  single-cycle strobe, once per second
- i_set_stb  input  1  single-cycle strobe at set rate (e.g. 4 Hz)
- i_set_hours  input  1  level, debounced "set hours" button
- i_set_minutes  input  1  level, debounced "set minutes" button
- o_seconds  output  6  seconds, 0-59
- o_minutes  output  6  minutes, 0-59
- o_hours  output  6  hours, 0-23; bit 5 always 0
- o_pm  output  1  PM flag; meaningful only with the optional feature
- o_rollover  output  1  one-cycle pulse on day wrap

Behaviour:
- Reset (i_reset_n low, asynchronous):
  - counters load RESET_* immediately;
  - o_rollover=0, o_pm=0;
  - state=RUN.
  - Reset mid-set aborts the set; no partial update survives.
- All outputs are registered. A field update is visible the cycle after the qualifying strobe.
- State machine, evaluated each cycle:
  - RUN -> SET when i_set_hours or i_set_minutes is high.
  - SET -> RUN when both are low.
  - The transition takes effect on the same edge the level is sampled.
- RUN: on i_1hz_stb with i_en=1:
  - seconds+1;
  - at 59, seconds -> 0 and minutes+1;
  - at 59, minutes -> 0 and hours+1;
  - at 23, hours -> 0.
  - The full carry chain resolves in one cycle: 23:59:59 -> 00:00:00 in a single edge.
  - o_rollover pulses high for exactly that cycle.
- RUN with i_en=0: counters hold; i_1hz_stb is ignored and not queued.
- SET: i_1hz_stb is ignored. Seconds are held at 0 throughout SET, forced on the first SET cycle.
- SET, on i_set_stb:
  - if i_set_minutes: minutes+1, wrapping 59 -> 0 with no carry into hours;
  - if i_set_hours: hours+1, wrapping 23 -> 0;
  - both held: both fields step on the same strobe.
  - Set wraps never assert o_rollover.
- i_en has no effect on SET; setting works while counting is disabled.
- Leaving SET: seconds are 0. The first i_1hz_stb in RUN makes seconds=1.
- Set input and i_1hz_stb in the same cycle: SET semantics win; no count occurs.
- i_set_stb in RUN: ignored.
- No internal prescaler. Strobes are assumed synchronous, one cycle wide.

Optional Feature:
- Macro: CLOCK_12HR_EN.
- Defined (12-hour mode):
  - hours range 1-12 and o_pm is active;
  - reset loads hours=12, o_pm=0, ignoring RESET_HOURS;
  - counting: 11:59:59 -> 12:00:00 toggles o_pm; 12:59:59 -> 01:00:00 leaves o_pm unchanged;
  - o_rollover pulses on 11:59:59 PM -> 12:00:00 AM;
  - hours set steps 12 -> 1 -> ... -> 11 -> 12, and 11 -> 12 toggles o_pm.
- Undefined: 24-hour behaviour as above; o_pm tied 0.

Test Plan:
1. Reset defaults, then 61 i_1hz_stb with i_en=1 -> 00:01:01, o_rollover never asserted.
2. Preload near midnight via set (hours to 23, minutes to 59), release, 59 strobes to 23:59:59, one more strobe -> 00:00:00 with o_rollover high exactly one cycle.
3. Hold i_set_minutes from 00:58:37: first cycle seconds=0; two i_set_stb -> 00:00:00 (59 wrapped to 0), hours unchanged; concurrent i_1hz_stb ignored.
4. Hold both set inputs, 25 i_set_stb from 00:00 -> hours=1, minutes=25; release; i_en=0 plus 10 i_1hz_stb -> no change; i_en=1 plus 1 strobe -> seconds=1.
5. Assert i_reset_n low asynchronously (between clock edges) mid-SET at 13:42 -> outputs immediately RESET_* (00:00:00), state RUN after release.
6. CLOCK_12HR_EN: from reset 12:00:00 AM, set hours to 11, count through 11:59:59 -> 12:00:00 with o_pm=1; continue to 12:59:59 -> 01:00:00, o_pm=1.
